enemy_unit: RTL and testbench

ENEMY_UNIT -- requirements
Module: enemy_unit

---
 rtl/enemy_unit_if.sv | 40 ++++
 rtl/enemy_unit.sv | 163 ++++++++++++++++
 tb/tb_enemy_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_unit_if.sv
// Enemy unit port bundle: frame strobe, spawn column and bullet inputs in,
// enemy position, status flags and score out.
//
// Timing contract: there is no valid/ready handshake and no backpressure.
// frameTick is a one-cycle strobe that counts as a frame only in the cycle
// it is high. spawnX and all bullet fields are level signals that the enemy
// samples on every rising clk edge. All outputs are either registered or
// decoded from the registered state, so they stay stable for a whole cycle.
interface enemy_unit_if;
   logic       frameTick;
   logic [7:0] spawnX;
   logic [7:0] bulletX;
   logic [6:0] bulletY;
   logic       bulletActive;
   logic [7:0] enemyX;
   logic [6:0] enemyY;
   logic       enemyVisible;
   logic       collidedWithEnemy;
   logic       escaped;
   logic [7:0] score;
   logic       inSpawnState;
   logic       inWaitState;
   logic       inMoveState;
   logic       inHitState;
   logic [2:0] state_dbg;

   // Driver side: game logic and the bullet controller
   modport master (
      output frameTick, spawnX, bulletX, bulletY, bulletActive,
      input  enemyX, enemyY, enemyVisible, collidedWithEnemy, escaped, score,
      input  inSpawnState, inWaitState, inMoveState, inHitState, state_dbg
   );

   // Enemy side
   modport slave (
      input  frameTick, spawnX, bulletX, bulletY, bulletActive,
      output enemyX, enemyY, enemyVisible, collidedWithEnemy, escaped, score,
      output inSpawnState, inWaitState, inMoveState, inHitState, state_dbg
   );
endinterface

// File: rtl/enemy_unit.sv
// Single falling enemy: spawns at a clamped random column, descends one
// pixel every STEP_FRAMES frames, registers bullet hits (saturating score),
// reports escapes off the bottom edge and waits RESPAWN_FRAMES before
// spawning again. state_dbg exposes the raw state register.
module enemy_unit #(
   parameter int SCREEN_W       = 160,
   parameter int SCREEN_H       = 120,
   parameter int ENEMY_W        = 8,
   parameter int ENEMY_H        = 8,
   parameter int STEP_FRAMES    = 4,
   parameter int RESPAWN_FRAMES = 30
) (
   input  logic         clk,
   input  logic         reset,
   enemy_unit_if.slave  bus
);

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_SPAWN = 3'd1,
      S_WAIT  = 3'd2,
      S_MOVE  = 3'd3,
      S_HIT   = 3'd4,
      S_DELAY = 3'd5
   } state_t;

   localparam logic [7:0] X_MAX      = 8'(SCREEN_W - ENEMY_W);
   localparam logic [6:0] Y_MAX      = 7'(SCREEN_H - ENEMY_H);
   localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
   localparam logic [7:0] DELAY_LAST = 8'(RESPAWN_FRAMES - 1);

   state_t     state_q, state_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [7:0] step_q, step_d;
   logic [7:0] delay_q, delay_d;
   logic       hit_tick_q, hit_tick_d;   // one frameTick already seen in S_HIT
   logic [7:0] score_q, score_d;
   logic       esc_q, esc_d;

   logic [8:0] x_lo, x_hi, y_lo, y_hi, bx9, by9;
   logic       hit;

   // Bullet-vs-sprite overlap; 9-bit bounds so x+7 / y+7 cannot wrap
   always_comb begin
      x_lo = {1'b0, x_q};
      x_hi = {1'b0, x_q} + 9'(ENEMY_W - 1);
      y_lo = {2'b00, y_q};
      y_hi = {2'b00, y_q} + 9'(ENEMY_H - 1);
      bx9  = {1'b0, bus.bulletX};
      by9  = {2'b00, bus.bulletY};
      hit  = bus.bulletActive && (bx9 >= x_lo) && (bx9 <= x_hi)
                              && (by9 >= y_lo) && (by9 <= y_hi);
   end

   // Next-state and datapath updates for every state
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      step_d     = step_q;
      delay_d    = delay_q;
      hit_tick_d = hit_tick_q;
      score_d    = score_q;
      esc_d      = 1'b0;
      case (state_q)
         S_RESET: state_d = S_SPAWN;
         S_SPAWN: begin
            x_d     = (bus.spawnX > X_MAX) ? X_MAX : bus.spawnX;
            y_d     = 7'd0;
            step_d  = 8'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A hit wins over a frame tick arriving in the same cycle
            if (hit) begin
               state_d    = S_HIT;
               hit_tick_d = 1'b0;
               score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else if (bus.frameTick) begin
               if (step_q == STEP_LAST) begin
                  step_d  = 8'd0;
                  state_d = S_MOVE;
               end else begin
                  step_d = step_q + 8'd1;
               end
            end
         end
         S_MOVE: begin
            // No collision test here; the following S_WAIT sees the new row
            if (y_q == Y_MAX) begin
               esc_d   = 1'b1;
               delay_d = 8'd0;
               state_d = S_DELAY;
            end else begin
               y_d     = y_q + 7'd1;
               state_d = S_WAIT;
            end
         end
         S_HIT: begin
            // Leave once the bullet has been retired, or after two frames
            if (!bus.bulletActive) begin
               delay_d = 8'd0;
               state_d = S_DELAY;
            end else if (bus.frameTick) begin
               if (hit_tick_q) begin
                  delay_d = 8'd0;
                  state_d = S_DELAY;
               end else begin
                  hit_tick_d = 1'b1;
               end
            end
         end
         S_DELAY: begin
            if (bus.frameTick) begin
               if (delay_q == DELAY_LAST) begin
                  state_d = S_SPAWN;
               end else begin
                  delay_d = delay_q + 8'd1;
               end
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RESET;
         x_q        <= 8'd0;
         y_q        <= 7'd0;
         step_q     <= 8'd0;
         delay_q    <= 8'd0;
         hit_tick_q <= 1'b0;
         score_q    <= 8'd0;
         esc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         step_q     <= step_d;
         delay_q    <= delay_d;
         hit_tick_q <= hit_tick_d;
         score_q    <= score_d;
         esc_q      <= esc_d;
      end
   end

   // Outputs: registers and pure decodes of the current state
   assign bus.enemyX            = x_q;
   assign bus.enemyY            = y_q;
   assign bus.score             = score_q;
   assign bus.escaped           = esc_q;
   assign bus.inSpawnState      = (state_q == S_SPAWN);
   assign bus.inWaitState       = (state_q == S_WAIT);
   assign bus.inMoveState       = (state_q == S_MOVE);
   assign bus.inHitState        = (state_q == S_HIT);
   assign bus.enemyVisible      = (state_q == S_WAIT) || (state_q == S_MOVE);
   assign bus.collidedWithEnemy = (state_q == S_HIT);
   assign bus.state_dbg         = state_q;

endmodule

// File: tb/tb_enemy_unit.sv
// Bench for enemy_unit: directed scenarios plus randomized play, all checked
// cycle by cycle against a behavioural model of the enemy's rules.
module tb_enemy_unit;

   localparam int SCREEN_W       = 160;
   localparam int SCREEN_H       = 120;
   localparam int ENEMY_W        = 8;
   localparam int ENEMY_H        = 8;
   localparam int STEP_FRAMES    = 4;
   localparam int RESPAWN_FRAMES = 30;
   localparam int W              = 33;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   enemy_unit_if bus ();

   enemy_unit #(
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ENEMY_W(ENEMY_W),
      .ENEMY_H(ENEMY_H), .STEP_FRAMES(STEP_FRAMES),
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   int n_esc  = 0;
   int n_move = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase numbers: 0 reset, 1 spawn, 2 wait, 3 move, 4 hit, 5 delay
   int m_ph, m_x, m_y, m_frames, m_delay, m_hit_frames, m_score, m_esc, m_hits;

   task automatic model_step(input bit rst);
      int nph;
      bit hit;
      int bx, by;
      if (rst) begin
         m_ph = 0; m_x = 0; m_y = 0; m_frames = 0; m_delay = 0;
         m_hit_frames = 0; m_score = 0; m_esc = 0;
      end else begin
         nph   = m_ph;
         m_esc = 0;
         bx    = int'(bus.bulletX);
         by    = int'(bus.bulletY);
         hit   = bus.bulletActive && bx >= m_x && bx < m_x + ENEMY_W
                                  && by >= m_y && by < m_y + ENEMY_H;
         case (m_ph)
            0: nph = 1;
            1: begin
               m_x = (int'(bus.spawnX) > SCREEN_W - ENEMY_W) ? SCREEN_W - ENEMY_W : int'(bus.spawnX);
               m_y = 0; m_frames = 0; nph = 2;
            end
            2: begin
               if (hit) begin
                  nph = 4; m_hit_frames = 0; m_hits++;
                  if (m_score < 255) m_score++;
               end else if (bus.frameTick) begin
                  m_frames++;
                  if (m_frames == STEP_FRAMES) begin m_frames = 0; nph = 3; end
               end
            end
            3: begin
               if (m_y == SCREEN_H - ENEMY_H) begin m_esc = 1; m_delay = 0; nph = 5; end
               else begin m_y++; nph = 2; end
            end
            4: begin
               if (!bus.bulletActive) begin m_delay = 0; nph = 5; end
               else if (bus.frameTick) begin
                  m_hit_frames++;
                  if (m_hit_frames == 2) begin m_delay = 0; nph = 5; end
               end
            end
            5: begin
               if (bus.frameTick) begin
                  m_delay++;
                  if (m_delay == RESPAWN_FRAMES) nph = 1;
               end
            end
            default: nph = 0;
         endcase
         m_ph = nph;
      end
   endtask

   function automatic logic [W-1:0] model_pack();
      logic [2:0] st;
      st = 3'(m_ph);
      return {st, m_ph == 1, m_ph == 2, m_ph == 3, m_ph == 4,
              (m_ph == 2 || m_ph == 3), m_ph == 4, m_esc != 0,
              8'(m_score), 7'(m_y), 8'(m_x)};
   endfunction

   task automatic compare();
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("enemyX",    32'(bus.enemyX),            32'(e[7:0]));
      check("enemyY",    32'(bus.enemyY),            32'(e[14:8]));
      check("score",     32'(bus.score),             32'(e[22:15]));
      check("escaped",   32'(bus.escaped),           32'(e[23]));
      check("collided",  32'(bus.collidedWithEnemy), 32'(e[24]));
      check("visible",   32'(bus.enemyVisible),      32'(e[25]));
      check("flags",     32'({bus.inSpawnState, bus.inWaitState, bus.inMoveState, bus.inHitState}),
                         32'(e[29:26]));
      check("state_dbg", 32'(bus.state_dbg),         32'(e[32:30]));
   endtask

   // ---------------- driver tasks ----------------
   // One clock: model advances on the same inputs the DUT samples.
   task automatic step(input bit rst);
      reset = rst;
      model_step(rst);
      exp_q.push_back(model_pack());
      @(posedge clk);
      #1;
      compare();
      if (bus.escaped)     n_esc++;
      if (bus.inMoveState) n_move++;
   endtask

   task automatic tick_pairs(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frameTick = 1'b1; step(0);
         bus.frameTick = 1'b0; step(0);
      end
   endtask

   task automatic do_reset();
      bus.frameTick = 1'b0; bus.bulletActive = 1'b0;
      step(1); step(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int off;
      reset = 1'b1;
      bus.frameTick = 1'b0; bus.spawnX = 8'd40; bus.bulletX = 8'd0;
      bus.bulletY = 7'd0; bus.bulletActive = 1'b0;
      m_hits = 0;

      // Reset values, then spawn at column 40
      do_reset();
      check("rst_score", 32'(bus.score), 0);
      check("rst_flags", 32'({bus.inSpawnState, bus.inWaitState, bus.inMoveState, bus.inHitState}), 0);
      step(0);
      check("spawn_flag", 32'(bus.inSpawnState), 1);
      step(0);
      check("spawn_x", 32'(bus.enemyX), 40);
      check("spawn_vis", 32'(bus.enemyVisible), 1);

      // Descent: 4 frames give one move, 448 frames reach row 112
      n_move = 0; n_esc = 0;
      tick_pairs(4);
      check("first_move_count", 32'(n_move), 1);
      check("first_move_y", 32'(bus.enemyY), 1);
      tick_pairs(444);
      check("bottom_y", 32'(bus.enemyY), 112);
      check("no_esc_yet", 32'(n_esc), 0);
      bus.spawnX = 8'd200;
      tick_pairs(4);
      check("esc_once", 32'(n_esc), 1);
      check("esc_hold_y", 32'(bus.enemyY), 112);
      check("esc_vis", 32'(bus.enemyVisible), 0);

      // Respawn after the delay with a clamped column
      tick_pairs(30);
      check("respawn_wait", 32'(bus.inWaitState), 1);
      check("clamp_x", 32'(bus.enemyX), 152);

      // Hit boundary at (40,10)
      bus.spawnX = 8'd40;
      do_reset();
      step(0); step(0);
      tick_pairs(40);
      check("hit_pos_y", 32'(bus.enemyY), 10);
      bus.bulletActive = 1'b1; bus.bulletX = 8'd48; bus.bulletY = 7'd17;
      step(0);
      check("miss_edge", 32'(bus.inHitState), 0);
      bus.bulletX = 8'd47;
      step(0);
      check("hit_edge", 32'(bus.inHitState), 1);
      check("hit_coll", 32'(bus.collidedWithEnemy), 1);
      check("hit_score", 32'(bus.score), 1);
      bus.bulletActive = 1'b0;
      step(0);
      check("hit_to_delay", 32'({bus.enemyVisible, bus.inHitState}), 0);
      tick_pairs(29);
      bus.frameTick = 1'b1; step(0);
      check("delay_to_spawn", 32'(bus.inSpawnState), 1);
      bus.frameTick = 1'b0; step(0);

      // Randomized play until the score saturates and a few more hits land
      m_hits = 0;
      cyc = 0;
      while (m_hits < 258 && cyc < 30000) begin
         bus.frameTick    = ($urandom_range(0, 3) != 0);
         bus.bulletActive = ($urandom_range(0, 7) != 0);
         bus.spawnX       = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            off = int'($urandom_range(0, 9)) - 1;
            bus.bulletX = 8'(m_x + off);
            off = int'($urandom_range(0, 9)) - 1;
            bus.bulletY = 7'(m_y + off);
         end else begin
            bus.bulletX = 8'($urandom_range(0, 255));
            bus.bulletY = 7'($urandom_range(0, 127));
         end
         step(0);
         cyc++;
      end
      check("score_sat", 32'(bus.score), 255);

      // Reset while in the respawn delay
      bus.bulletActive = 1'b0;
      cyc = 0;
      while (m_ph != 5 && cyc < 2000) begin
         bus.frameTick = ($urandom_range(0, 1) != 0);
         step(0);
         cyc++;
      end
      check("pre_rst_delay", 32'({bus.enemyVisible, bus.inSpawnState, bus.inWaitState,
                                  bus.inMoveState, bus.inHitState}), 0);
      check("pre_rst_dbg", 32'(bus.state_dbg), 5);
      step(1);
      check("rst_dbg", 32'(bus.state_dbg), 0);
      check("rst_score2", 32'(bus.score), 0);
      check("rst_xy", 32'({bus.enemyX, bus.enemyY}), 0);
      check("rst_outs", 32'({bus.escaped, bus.collidedWithEnemy, bus.enemyVisible}), 0);
      step(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
